// File: rtl/ppg_autocal_ctrl.sv
// ---------------------------------------------------------------------------
// ppg_autocal_ctrl
//
// Closed-loop calibration controller for a PPG (finger-clip) analog front end.
// It watches the 8-bit PPG level on sample_tick and tracks the min/max over a
// measurement window. Between windows it first steps the DC compensation code
// until the waveform midpoint is centred. It then raises the PGA gain until
// the swing is large enough, backing off by one if the window clips.
//
// Ports
//   clk          in   1  system clock
//   rst          in   1  synchronous reset, active-high
//   start        in   1  one-cycle pulse, begins calibration (ignored while busy)
//   sample_tick  in   1  one-cycle strobe, Vppg valid this cycle
//   Vppg         in   8  front-end output level (0..255)
//   DC_Comp      out  7  DC compensation code to the front end
//   PGA_Gain     out  4  PGA gain code to the front end
//   busy         out  1  high from accepted start until done/fail
//   done         out  1  level, calibration locked
//   fail         out  1  level, iteration budget exhausted without lock
//   vmin, vmax   out  8  min/max of the last completed window
// ---------------------------------------------------------------------------
module ppg_autocal_ctrl #(
    parameter int unsigned WIN_SAMPLES    = 1100, // samples per measurement window
    parameter int unsigned SETTLE_SAMPLES = 4,    // samples discarded after a code change
    parameter int unsigned TARGET_MID     = 128,  // desired (max+min)/2
    parameter int unsigned MID_TOL        = 2,    // accepted midpoint error
    parameter int unsigned SWING_MIN      = 160,  // swing at which gain stepping stops
    parameter int unsigned MAX_ITER       = 128   // windows allowed before fail
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       sample_tick,
    input  logic [7:0] Vppg,
    output logic [6:0] DC_Comp,
    output logic [3:0] PGA_Gain,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [7:0] vmin,
    output logic [7:0] vmax
);

    // One sample counter serves both the settle and the measure phases.
    localparam int unsigned CNT_MAX = (WIN_SAMPLES > SETTLE_SAMPLES) ? WIN_SAMPLES : SETTLE_SAMPLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned ITER_W  = $clog2(MAX_ITER + 1);

    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_SAMPLES - 1);
    localparam logic [CNT_W-1:0]  WIN_LAST    = CNT_W'(WIN_SAMPLES - 1);
    localparam logic [ITER_W-1:0] ITER_LIMIT  = ITER_W'(MAX_ITER);
    localparam logic [8:0]        MID_HI      = 9'(TARGET_MID + MID_TOL);
    localparam logic [8:0]        MID_LO      = 9'(TARGET_MID - MID_TOL);
    localparam logic [8:0]        SWING_TGT   = 9'(SWING_MIN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_MEASURE,
        S_EVAL,
        S_LOCKED,
        S_FAILED
    } state_t;

    // DC phase centres the waveform; GAIN phase grows the swing.
    typedef enum logic {
        PH_DC,
        PH_GAIN
    } phase_t;

    state_t            state_q,  state_d;
    phase_t            phase_q,  phase_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [ITER_W-1:0] iter_q,   iter_d;
    logic [7:0]        min_q,    min_d;
    logic [7:0]        max_q,    max_d;
    logic [6:0]        dc_q,     dc_d;
    logic [3:0]        gain_q,   gain_d;
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;
    logic              fail_q,   fail_d;
    logic [7:0]        vmin_q,   vmin_d;
    logic [7:0]        vmax_q,   vmax_d;

    // Window statistics evaluated in the EVAL cycle. The sum is 9 bits so the
    // midpoint truncates rather than wraps.
    logic [8:0] mid_sum;
    logic [8:0] mid;
    logic [7:0] swing;
    logic       clip_hi;
    logic       clip_lo;
    logic       clip;
    logic [6:0] dc_inc;
    logic [6:0] dc_dec;

    assign mid_sum = {1'b0, max_q} + {1'b0, min_q};
    assign mid     = {1'b0, mid_sum[8:1]};
    assign swing   = max_q - min_q;
    assign clip_hi = (max_q == 8'hFF);
    assign clip_lo = (min_q == 8'h00);
    assign clip    = clip_hi | clip_lo;

    // Saturating DC steps: a request past either rail leaves the code
    // unchanged and simply burns an iteration.
    assign dc_inc  = (dc_q == 7'd127) ? dc_q : dc_q + 7'd1;
    assign dc_dec  = (dc_q == 7'd0)   ? dc_q : dc_q - 7'd1;

    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case leaves a
        // signal unassigned, which would otherwise infer a latch.
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        iter_d  = iter_q;
        min_d   = min_q;
        max_d   = max_q;
        dc_d    = dc_q;
        gain_d  = gain_q;
        busy_d  = busy_q;
        done_d  = done_q;
        fail_d  = fail_q;
        vmin_d  = vmin_q;
        vmax_d  = vmax_q;

        unique case (state_q)
            S_IDLE, S_LOCKED, S_FAILED: begin
                if (start) begin
                    done_d  = 1'b0;
                    fail_d  = 1'b0;
                    dc_d    = 7'd0;
                    gain_d  = 4'd0;
                    iter_d  = '0;
                    cnt_d   = '0;
                    phase_d = PH_DC;
                    busy_d  = 1'b1;
                    state_d = S_SETTLE;
                end
            end

            S_SETTLE: begin
                // Samples here reflect the front end still reacting to the
                // last code change and are never captured.
                if (sample_tick) begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_d   = '0;
                        min_d   = 8'hFF;
                        max_d   = 8'h00;
                        state_d = S_MEASURE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            S_MEASURE: begin
                if (sample_tick) begin
                    min_d = (Vppg < min_q) ? Vppg : min_q;
                    max_d = (Vppg > max_q) ? Vppg : max_q;
                    if (cnt_q == WIN_LAST) begin
                        // Publish the window including the final sample.
                        cnt_d   = '0;
                        vmin_d  = min_d;
                        vmax_d  = max_d;
                        state_d = S_EVAL;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            S_EVAL: begin
                // sample_tick is deliberately ignored here: that sample
                // belongs to no window.
                iter_d  = iter_q + ITER_W'(1);
                state_d = S_SETTLE;

                if (phase_q == PH_DC) begin
                    if (clip_hi && !clip_lo) begin
                        dc_d = dc_inc;
                    end else if (clip_lo && !clip_hi) begin
                        dc_d = dc_dec;
                    end else if (clip_hi && clip_lo) begin
                        // Swing wider than the ADC range: shrink gain first.
                        if (gain_q != 4'd0) begin
                            gain_d = gain_q - 4'd1;
                        end else begin
                            dc_d = dc_inc;
                        end
                    end else if (mid > MID_HI) begin
                        dc_d = dc_inc;
                    end else if (mid < MID_LO) begin
                        dc_d = dc_dec;
                    end else begin
                        phase_d = PH_GAIN;
                    end
                end else begin
                    if (clip && (gain_q != 4'd0)) begin
                        gain_d  = gain_q - 4'd1;
                        state_d = S_LOCKED;
                    end else if (!clip && ({1'b0, swing} < SWING_TGT) && (gain_q != 4'd15)) begin
                        gain_d = gain_q + 4'd1;
                    end else begin
                        state_d = S_LOCKED;
                    end
                end

                if (state_d == S_LOCKED) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end else if (iter_d == ITER_LIMIT) begin
                    state_d = S_FAILED;
                    busy_d  = 1'b0;
                    fail_d  = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            phase_q <= PH_DC;
            cnt_q   <= '0;
            iter_q  <= '0;
            min_q   <= 8'h00;
            max_q   <= 8'h00;
            dc_q    <= 7'd0;
            gain_q  <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
            vmin_q  <= 8'h00;
            vmax_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            iter_q  <= iter_d;
            min_q   <= min_d;
            max_q   <= max_d;
            dc_q    <= dc_d;
            gain_q  <= gain_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fail_q  <= fail_d;
            vmin_q  <= vmin_d;
            vmax_q  <= vmax_d;
        end
    end

    assign DC_Comp  = dc_q;
    assign PGA_Gain = gain_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign fail     = fail_q;
    assign vmin     = vmin_q;
    assign vmax     = vmax_q;

endmodule
